pipe_ctrl: RTL and testbench

Pipeline stall/flush controller for the six-stage in-order core (PC, IF, ID, EX, MEM, WB). It merges ID-stage load-use stall requests, EX-stage multi-cycle operation requests (div/madd) and exception flush requests into one per-stage stall vector. It sequences multi-cycle EX holds with an internal down-counter and keeps a stall-cycle performance counter. It sits beside the pipeline registers and drives their hold/flush inputs.

---
 rtl/pipe_ctrl_if.sv | 26 ++
 rtl/pipe_ctrl.sv | 87 ++++++++
 tb/tb_pipe_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush controller.
interface pipe_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             stallreq_id;
    logic             ex_busy_start;
    logic [CNT_W-1:0] ex_cycles;
    logic             ex_done;
    logic             flush_req;
    logic [31:0]      flush_pc;
    logic [5:0]       stall_o;
    logic             flush_o;
    logic [31:0]      new_pc_o;
    logic             ex_busy_o;
    logic [31:0]      stall_cnt_o;

    // master: the pipeline raising requests; slave: the controller.
    modport master (
        output stallreq_id, ex_busy_start, ex_cycles, ex_done, flush_req, flush_pc,
        input  stall_o, flush_o, new_pc_o, ex_busy_o, stall_cnt_o
    );
    modport slave (
        input  stallreq_id, ex_busy_start, ex_cycles, ex_done, flush_req, flush_pc,
        output stall_o, flush_o, new_pc_o, ex_busy_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the six-stage core: merges load-use, multi-cycle EX
// and flush requests into per-stage hold/flush controls, plus a stall-cycle counter.
module pipe_ctrl #(
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, MULTI} state_t;

    localparam logic [5:0] STALL_EX = 6'b001111;
    localparam logic [5:0] STALL_ID = 6'b000111;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic [31:0]      stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = '0;
        flush     = 1'b0;
        new_pc    = '0;
        if (rst) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (bus.flush_req) begin
            // Flush abandons any multi-cycle op, including a start this cycle.
            flush     = 1'b1;
            new_pc    = bus.flush_pc;
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.ex_busy_start && bus.ex_cycles != '0) begin
                        stall = STALL_EX;
                        if (bus.ex_cycles >= CNT_W'(2)) begin
                            state_nxt = MULTI;
                            cnt_nxt   = bus.ex_cycles - CNT_W'(1);
                        end
                    end else if (bus.stallreq_id) begin
                        stall = STALL_ID;
                    end
                end
                MULTI: begin
                    // A start arriving here is a protocol error and is dropped.
                    stall   = STALL_EX;
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1) || bus.ex_done) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)           stall_cnt <= '0;
        else if (stall[2]) stall_cnt <= stall_cnt + 32'd1;
    end

    assign bus.stall_o     = stall;
    assign bus.flush_o     = flush;
    assign bus.new_pc_o    = new_pc;
    assign bus.ex_busy_o   = (state == MULTI) && !rst;
    assign bus.stall_cnt_o = stall_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change just after a rising edge, outputs
// are sampled mid-cycle against hand-computed values.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   errs = 0;
    int   checks = 0;

    pipe_ctrl_if #(.CNT_W(6)) bus ();
    pipe_ctrl #(.CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.stallreq_id = 0; bus.ex_busy_start = 0; bus.ex_cycles = '0;
        bus.ex_done = 0; bus.flush_req = 0; bus.flush_pc = '0;
        tick(); tick();

        // Reset while in MULTI with cnt=5
        rst = 1'b0;
        bus.ex_busy_start = 1; bus.ex_cycles = 6'd6;
        tick();
        bus.ex_busy_start = 0;
        #1 chk("multi_before_rst_busy", 32'(bus.ex_busy_o), 32'd1);
        rst = 1'b1; bus.stallreq_id = 1;
        #1 chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_busy", 32'(bus.ex_busy_o), 32'd0);
        chk("rst_flush", 32'(bus.flush_o), 32'd0);
        tick();
        #1 chk("rst2_cnt", bus.stall_cnt_o, 32'd0);
        chk("rst2_busy", 32'(bus.ex_busy_o), 32'd0);
        tick();
        rst = 1'b0; bus.stallreq_id = 0;
        #1 chk("post_rst_stall", 32'(bus.stall_o), 32'd0);
        chk("post_rst_busy", 32'(bus.ex_busy_o), 32'd0);

        // Load-use bubble
        bus.stallreq_id = 1;
        #1 chk("loaduse_stall", 32'(bus.stall_o), 32'h07);
        chk("loaduse_flush", 32'(bus.flush_o), 32'd0);
        tick();
        bus.stallreq_id = 0;
        #1 chk("loaduse_after", 32'(bus.stall_o), 32'd0);
        chk("loaduse_cnt", bus.stall_cnt_o, 32'd1);

        // Four-cycle op
        bus.ex_busy_start = 1; bus.ex_cycles = 6'd4;
        #1 chk("m4_start_stall", 32'(bus.stall_o), 32'h0F);
        chk("m4_start_busy", 32'(bus.ex_busy_o), 32'd0);
        tick();
        bus.ex_busy_start = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("m4_stall%0d", i), 32'(bus.stall_o), 32'h0F);
            chk($sformatf("m4_busy%0d", i), 32'(bus.ex_busy_o), 32'd1);
            tick();
        end
        #1 chk("m4_end_stall", 32'(bus.stall_o), 32'd0);
        chk("m4_end_busy", 32'(bus.ex_busy_o), 32'd0);
        chk("m4_cnt", bus.stall_cnt_o, 32'd5);

        // Back-to-back start in the first IDLE cycle, load-use ignored in MULTI
        bus.ex_busy_start = 1; bus.ex_cycles = 6'd2;
        #1 chk("b2b_start_stall", 32'(bus.stall_o), 32'h0F);
        tick();
        bus.ex_busy_start = 0; bus.stallreq_id = 1;
        #1 chk("b2b_multi_stall", 32'(bus.stall_o), 32'h0F);
        chk("b2b_multi_busy", 32'(bus.ex_busy_o), 32'd1);
        tick();
        bus.stallreq_id = 0;
        #1 chk("b2b_end_stall", 32'(bus.stall_o), 32'd0);
        chk("b2b_end_busy", 32'(bus.ex_busy_o), 32'd0);
        chk("b2b_cnt", bus.stall_cnt_o, 32'd7);

        // Early done on the fifth stalled cycle of a 32-cycle op
        bus.ex_busy_start = 1; bus.ex_cycles = 6'd32;
        #1 chk("done_start_stall", 32'(bus.stall_o), 32'h0F);
        tick();
        bus.ex_busy_start = 0;
        for (int i = 1; i <= 4; i++) begin
            bus.ex_done = (i == 4);
            #1 chk($sformatf("done_stall%0d", i), 32'(bus.stall_o), 32'h0F);
            tick();
            bus.ex_done = 0;
        end
        #1 chk("done_end_stall", 32'(bus.stall_o), 32'd0);
        chk("done_end_busy", 32'(bus.ex_busy_o), 32'd0);
        chk("done_cnt", bus.stall_cnt_o, 32'd12);

        // Flush in the second MULTI cycle of a 10-cycle op
        bus.ex_busy_start = 1; bus.ex_cycles = 6'd10;
        tick();
        bus.ex_busy_start = 0;
        #1 chk("fl_m1_stall", 32'(bus.stall_o), 32'h0F);
        tick();
        bus.flush_req = 1; bus.flush_pc = 32'h0000_0180;
        #1 chk("fl_stall", 32'(bus.stall_o), 32'd0);
        chk("fl_flush", 32'(bus.flush_o), 32'd1);
        chk("fl_newpc", bus.new_pc_o, 32'h180);
        tick();
        bus.flush_req = 0; bus.flush_pc = 32'h0;
        #1 chk("fl_after_busy", 32'(bus.ex_busy_o), 32'd0);
        chk("fl_after_stall", 32'(bus.stall_o), 32'd0);
        chk("fl_after_flush", 32'(bus.flush_o), 32'd0);
        chk("fl_after_newpc", bus.new_pc_o, 32'd0);
        chk("fl_cnt", bus.stall_cnt_o, 32'd14);

        // Flush in the last MULTI cycle wins
        bus.ex_busy_start = 1; bus.ex_cycles = 6'd2;
        tick();
        bus.ex_busy_start = 0; bus.flush_req = 1; bus.flush_pc = 32'h0000_0200;
        #1 chk("fl_last_stall", 32'(bus.stall_o), 32'd0);
        chk("fl_last_newpc", bus.new_pc_o, 32'h200);
        tick();
        bus.flush_req = 0;
        #1 chk("fl_last_busy", 32'(bus.ex_busy_o), 32'd0);
        chk("fl_last_cnt", bus.stall_cnt_o, 32'd15);

        // Single-cycle op together with load-use
        bus.ex_busy_start = 1; bus.ex_cycles = 6'd1; bus.stallreq_id = 1;
        #1 chk("sim1_stall", 32'(bus.stall_o), 32'h0F);
        tick();
        bus.ex_busy_start = 0; bus.stallreq_id = 0;
        #1 chk("sim1_after_stall", 32'(bus.stall_o), 32'd0);
        chk("sim1_busy", 32'(bus.ex_busy_o), 32'd0);
        chk("sim1_cnt", bus.stall_cnt_o, 32'd16);

        // Flush together with a start
        bus.ex_busy_start = 1; bus.ex_cycles = 6'd5;
        bus.flush_req = 1; bus.flush_pc = 32'hDEAD_BEE0;
        #1 chk("flst_stall", 32'(bus.stall_o), 32'd0);
        chk("flst_flush", 32'(bus.flush_o), 32'd1);
        chk("flst_newpc", bus.new_pc_o, 32'hDEAD_BEE0);
        tick();
        bus.ex_busy_start = 0; bus.flush_req = 0;
        #1 chk("flst_busy", 32'(bus.ex_busy_o), 32'd0);
        chk("flst_after_stall", 32'(bus.stall_o), 32'd0);
        chk("flst_cnt", bus.stall_cnt_o, 32'd16);

        // Zero-length op
        bus.ex_busy_start = 1; bus.ex_cycles = 6'd0;
        #1 chk("zero_stall", 32'(bus.stall_o), 32'd0);
        tick();
        bus.ex_busy_start = 0;
        #1 chk("zero_busy", 32'(bus.ex_busy_o), 32'd0);
        chk("zero_cnt", bus.stall_cnt_o, 32'd16);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
